// File: rtl/bram_fifo_axis_reader_pkg.sv
// Shared pointer types and helpers for the BRAM FIFO controller and its stream reader.
// ptr_t is sized for the widest supported FIFO; narrower pointers are zero-extended.
package bram_fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 10;
   localparam int BRAM_RD_LATENCY = 1;

   typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

   function automatic ptr_t ptr_level(input ptr_t wr, input ptr_t rd);
      return wr - rd;
   endfunction

   function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd);
      return wr == rd;
   endfunction

endpackage

// File: rtl/bram_fifo_axis_reader_if.sv
// AXI4-Stream channel between the FIFO reader and its sink.
interface bram_fifo_axis_reader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_fifo_axis_reader_skid_buf.sv
// Two-entry output buffer: head_q drives the stream, spare_q absorbs the prefetched word.
module bram_fifo_skid_buf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic [1:0]            count_o
);

   logic [DATA_WIDTH-1:0] head_q, head_d, spare_q, spare_d;
   logic [1:0]            count_q, count_d;

   always_comb begin
      head_d  = head_q;
      spare_d = spare_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_d  = push_data_i;
                  count_d = 2'd1;
               end else begin
                  spare_d = push_data_i;
                  count_d = 2'd2;
               end
            end
            2'b01: begin
               head_d  = spare_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the new word goes behind whatever is still queued
               if (count_q == 2'd2) begin
                  head_d  = spare_q;
                  spare_d = push_data_i;
               end else begin
                  head_d = push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         spare_q <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         spare_q <= spare_d;
         count_q <= count_d;
      end
   end

   assign data_o  = head_q;
   assign valid_o = (count_q != 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/bram_fifo_axis_reader.sv
// Prefetching reader: pulls committed words out of BRAM port B and streams them as AXI4-Stream.
// ADDR_WIDTH must not exceed bram_fifo_pkg::FIFO_ADDR_WIDTH.
module bram_fifo_axis_reader
   import bram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int PKT_LEN    = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH:0]     wr_ptr_i,
   output logic [ADDR_WIDTH:0]     rd_ptr_o,
   input  logic                    flush_i,
   output logic                    bram_en_o,
   output logic [ADDR_WIDTH-1:0]   bram_addr_o,
   input  logic [DATA_WIDTH-1:0]   bram_dout_i,
   bram_fifo_axis_reader_if.master m_axis,
   output logic                    empty_o,
   output logic [ADDR_WIDTH:0]     level_o
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0]              fetch_q, fetch_d, rd_q, rd_d;
   logic [BRAM_RD_LATENCY-1:0] inflight_q, inflight_d;
   logic [15:0]                beat_q, beat_d;
   logic [1:0]                 occ;
   logic [2:0]                 pending;
   logic                       buf_valid, avail, issue, pop, capture, tlast;
   logic [DATA_WIDTH-1:0]      buf_data;

   always_comb begin
      avail   = (fetch_q != wr_ptr_i);
      pop     = buf_valid && m_axis.tready;
      capture = inflight_q[BRAM_RD_LATENCY-1] && !flush_i;
      pending = {1'b0, occ} + 3'($countones(inflight_q));
      // reset gates the enable so an externally non-zero wr_ptr_i cannot start a read
      issue   = !ARESET && !flush_i && avail && (pending < (pop ? 3'd3 : 3'd2));
      tlast   = buf_valid && (beat_q == 16'(PKT_LEN - 1));

      fetch_d    = fetch_q;
      rd_d       = rd_q;
      inflight_d = (inflight_q << 1) | BRAM_RD_LATENCY'(issue);
      beat_d     = beat_q;
      if (flush_i) begin
         fetch_d    = wr_ptr_i;
         rd_d       = wr_ptr_i;
         inflight_d = '0;
         beat_d     = 16'd0;
      end else begin
         if (issue)   fetch_d = fetch_q + PW'(1);
         if (capture) rd_d    = rd_q + PW'(1);
         if (pop)     beat_d  = tlast ? 16'd0 : beat_q + 16'd1;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         fetch_q    <= '0;
         rd_q       <= '0;
         inflight_q <= '0;
         beat_q     <= 16'd0;
      end else begin
         fetch_q    <= fetch_d;
         rd_q       <= rd_d;
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
      end
   end

   bram_fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk         (ACLK),
      .rst         (ARESET),
      .flush_i     (flush_i),
      .push_i      (capture),
      .push_data_i (bram_dout_i),
      .pop_i       (pop),
      .data_o      (buf_data),
      .valid_o     (buf_valid),
      .count_o     (occ)
   );

   assign m_axis.tdata  = buf_data;
   assign m_axis.tvalid = buf_valid;
   assign m_axis.tlast  = tlast;

   assign bram_en_o   = issue;
   assign bram_addr_o = fetch_q[ADDR_WIDTH-1:0];
   assign rd_ptr_o    = rd_q;
   assign level_o     = PW'(ptr_level(ptr_t'(wr_ptr_i), ptr_t'(rd_q)));
   assign empty_o     = ptr_empty(ptr_t'(wr_ptr_i), ptr_t'(rd_q)) && !buf_valid;

endmodule

// File: tb/tb_bram_fifo_axis_reader.sv
// Bench for bram_fifo_axis_reader with an 8-deep FIFO and 3-beat packets.
module tb_bram_fifo_axis_reader;

   localparam int DW      = 32;
   localparam int AW      = 3;
   localparam int DEPTH   = 8;
   localparam int PKT_LEN = 3;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic [AW:0]   wr_ptr_i = '0;
   logic [AW:0]   rd_ptr_o;
   logic          flush_i = 1'b0;
   logic          bram_en_o;
   logic [AW-1:0] bram_addr_o;
   logic [DW-1:0] bram_dout = '0;
   logic          empty_o;
   logic [AW:0]   level_o;

   bram_fifo_axis_reader_if #(.DATA_WIDTH(DW)) m_axis_if ();

   bram_fifo_axis_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LEN(PKT_LEN)) dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .wr_ptr_i    (wr_ptr_i),
      .rd_ptr_o    (rd_ptr_o),
      .flush_i     (flush_i),
      .bram_en_o   (bram_en_o),
      .bram_addr_o (bram_addr_o),
      .bram_dout_i (bram_dout),
      .m_axis      (m_axis_if),
      .empty_o     (empty_o),
      .level_o     (level_o)
   );

   always #5 ACLK = ~ACLK;

   logic [DW-1:0] mem [DEPTH];
   always @(posedge ACLK) if (bram_en_o) bram_dout <= mem[bram_addr_o];

   // reference model state
   logic [DW-1:0] exp_q[$];
   logic          log_last[$];
   int            m_total = 0, issued = 0, consumed = 0, wraps = 0;
   logic [AW:0]   m_fetch = '0;
   logic [AW-1:0] prev_addr = '0;
   logic          prev_stall = 1'b0, prev_last = 1'b0, rand_ready = 1'b0;
   logic [DW-1:0] prev_data = '0;
   int            n_checks = 0, n_fail = 0;

   typedef struct {
      logic [AW:0] wr;
      logic        exp_empty;
      logic [AW:0] exp_level;
   } rst_vec_t;
   rst_vec_t rst_tab[4];

   typedef struct {
      int   beat;
      logic exp_last;
   } last_vec_t;
   last_vec_t last_tab[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sample();
      logic [DW-1:0] exp_d;
      logic          exp_l;
      @(negedge ACLK);
      if (ARESET) begin
         exp_q.delete();
         m_total = 0; issued = 0; consumed = 0;
         m_fetch = '0; prev_addr = '0; prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", m_axis_if.tvalid, 1);
            check("stall_data", m_axis_if.tdata, prev_data);
            check("stall_last", m_axis_if.tlast, prev_last);
         end
         if (m_axis_if.tvalid && m_axis_if.tready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_axis_if.tdata);
            end else begin
               exp_d = exp_q.pop_front();
               exp_l = ((m_total + 1) % PKT_LEN) == 0;
               check("beat_data", m_axis_if.tdata, exp_d);
               check("beat_last", m_axis_if.tlast, exp_l);
            end
            m_total++; consumed++;
            log_last.push_back(m_axis_if.tlast);
         end
         if (bram_en_o) begin
            check("bram_addr", bram_addr_o, m_fetch[AW-1:0]);
            if (prev_addr == 3'd7 && bram_addr_o == 3'd0) wraps++;
            prev_addr = bram_addr_o;
            m_fetch++; issued++;
            check("read_ahead", (issued - consumed) <= 2, 1);
         end
         prev_stall = m_axis_if.tvalid && !m_axis_if.tready && !flush_i;
         prev_data  = m_axis_if.tdata;
         prev_last  = m_axis_if.tlast;
         if (flush_i) begin
            exp_q.delete();
            m_total = 0; issued = 0; consumed = 0;
            m_fetch = wr_ptr_i;
         end
      end
   endtask

   task automatic adv();
      @(posedge ACLK);
      #1;
      if (rand_ready) m_axis_if.tready = 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      sample();
      adv();
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      int g = 0;
      while (exp_q.size() >= DEPTH && g < 500) begin tick(); g++; end
      if (g >= 500) check("push_timeout", 1, 0);
      mem[wr_ptr_i[AW-1:0]] = d;
      wr_ptr_i = wr_ptr_i + 1'b1;
      exp_q.push_back(d);
      tick();
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 300) begin tick(); g++; end
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      int lat;
      m_axis_if.tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rst_tab[0] = '{4'd0,  1'b1, 4'd0};
      rst_tab[1] = '{4'd3,  1'b0, 4'd3};
      rst_tab[2] = '{4'd8,  1'b0, 4'd8};
      rst_tab[3] = '{4'd15, 1'b0, 4'd15};
      for (int i = 0; i < 9; i++) last_tab[i] = '{i + 1, ((i + 1) % 3) == 0};

      // reset state, with combinational outputs swept over wr_ptr_i
      #2;
      for (int i = 0; i < 4; i++) begin
         wr_ptr_i = rst_tab[i].wr;
         #1;
         check("rst_empty", empty_o, rst_tab[i].exp_empty);
         check("rst_level", level_o, rst_tab[i].exp_level);
         check("rst_en", bram_en_o, 0);
         check("rst_tvalid", m_axis_if.tvalid, 0);
         check("rst_tlast", m_axis_if.tlast, 0);
         check("rst_tdata", m_axis_if.tdata, 0);
         check("rst_rd_ptr", rd_ptr_o, 0);
         check("rst_addr", bram_addr_o, 0);
      end
      wr_ptr_i = '0;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      m_axis_if.tready = 1'b1;

      // four words at once: latency and back-to-back throughput
      mem[0] = 32'h0101FFFF; mem[1] = 32'hABCD0001; mem[2] = 32'hDEAD0011; mem[3] = 32'hBEEF0011;
      for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
      wr_ptr_i = 4'd4;
      sample();
      check("first_en", bram_en_o, 1);
      lat = 0;
      do begin adv(); sample(); lat++; end while (!m_axis_if.tvalid && lat < 10);
      check("first_latency", lat, 2);
      for (int i = 0; i < 3; i++) begin adv(); sample(); end
      check("back_to_back", m_total, 4);
      adv();
      drain();
      check("t1_rd_ptr", rd_ptr_o, 4);
      check("t1_empty", empty_o, 1);

      // eight words with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_word($urandom);
         if ($urandom_range(0, 2) == 0) tick();
      end
      drain();

      // packet boundaries after a counter-clearing flush
      rand_ready = 1'b0;
      m_axis_if.tready = 1'b1;
      flush_i = 1'b1; tick(); flush_i = 1'b0;
      log_last.delete();
      for (int i = 0; i < 7; i++) push_word($urandom);
      drain();
      for (int i = 0; i < 2; i++) push_word($urandom);
      drain();
      check("pkt_beats", log_last.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < log_last.size()) check($sformatf("pkt_tlast_%0d", last_tab[i].beat), log_last[i], last_tab[i].exp_last);

      // 20 words around the 8-deep ring with random ready
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_word($urandom);
         if ($urandom_range(0, 3) == 0) tick();
      end
      drain();
      check("addr_wrapped", wraps >= 2, 1);

      // flush with one buffered beat and one read in flight
      rand_ready = 1'b0;
      m_axis_if.tready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         mem[4'(wr_ptr_i + 4'(i)) % DEPTH] = $urandom;
         exp_q.push_back(32'hBAD0_0000);
      end
      wr_ptr_i = wr_ptr_i + 4'd3;
      tick();
      tick();
      flush_i = 1'b1;
      sample();
      check("pre_flush_valid", m_axis_if.tvalid, 1);
      adv();
      flush_i = 1'b0;
      m_axis_if.tready = 1'b1;
      sample();
      check("flush_tvalid", m_axis_if.tvalid, 0);
      check("flush_rd_ptr", rd_ptr_o, wr_ptr_i);
      check("flush_level", level_o, 0);
      check("flush_empty", empty_o, 1);
      adv();
      for (int i = 0; i < 5; i++) tick();
      check("flush_no_reads", issued, 0);
      check("flush_no_beats", m_total, 0);
      for (int i = 0; i < 3; i++) push_word($urandom);
      drain();

      // asynchronous reset in the middle of a stream
      for (int i = 0; i < 4; i++) push_word($urandom);
      ARESET = 1'b1;
      #1;
      check("areset_tvalid", m_axis_if.tvalid, 0);
      check("areset_en", bram_en_o, 0);
      check("areset_rd_ptr", rd_ptr_o, 0);
      wr_ptr_i = 4'd2;
      mem[0] = 32'h1111_0000; mem[1] = 32'h2222_0001;
      sample();
      adv();
      ARESET = 1'b0;
      exp_q.push_back(32'h1111_0000);
      exp_q.push_back(32'h2222_0001);
      for (int i = 0; i < 10; i++) tick();
      check("post_rst_beats", m_total, 2);
      check("post_rst_reads", issued, 2);
      check("post_rst_rd_ptr", rd_ptr_o, 2);
      check("post_rst_empty", empty_o, 1);

      // completely full ring
      ARESET = 1'b1;
      wr_ptr_i = '0;
      m_axis_if.tready = 1'b0;
      tick();
      ARESET = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'hF000_0000 + 32'(i * 17);
         exp_q.push_back(mem[i]);
      end
      wr_ptr_i = 4'd8;
      sample();
      check("full_level", level_o, 8);
      check("full_empty", empty_o, 0);
      check("full_rd_ptr", rd_ptr_o, 0);
      adv();
      for (int i = 0; i < 6; i++) tick();
      m_axis_if.tready = 1'b1;
      drain();
      check("full_rd_end", rd_ptr_o, 8);
      check("full_level_end", level_o, 0);
      check("full_empty_end", empty_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
